alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), number of b bits used as shift count.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request; accepted only when busy=0.
REQ-006 SHALL have port op  input  8  operation code; only op[4:0] decoded.
REQ-007 SHALL have ports a, b  input  WIDTH  operands, sampled only at accepted start.
REQ-008 SHALL have port carry_in  input  1  carry/borrow for adc/sbc, sampled with a, b.
REQ-009 SHALL have port c  output  WIDTH  registered result.
REQ-010 SHALL have ports carry_out, is_zero, is_negative  output  1 each  registered flags.
REQ-011 SHALL have port div_by_zero  output  1  set with result of a div/rem op when b=0.
REQ-012 SHALL have ports busy  output  1  operation in progress; valid  output  1  one-cycle result strobe.

Function
REQ-013 SHALL decode op[4:0]: 0 add, 1 adc, 2 sub, 3 sbc, 4 or, 5 and, 6 not a, 7 xor, 8 cmp, 9 pass a, 12 shl, 13 shr1, 14 sar, 16 mul low-half, 17 mul low, 18 mul high, 20 udiv, 21 urem; others yield c=0, carry_out=0.
REQ-014 add/adc carry_out SHALL be the true carry out of a+b(+carry_in); sub/sbc carry_out SHALL be the borrow (1 when a < b(+carry_in), unsigned).
REQ-015 cmp SHALL give c = all ones if MSB of (a-b) is 1, else 0 if a=b, else 1; carry_out=0.
REQ-016 shl SHALL give a << b[SHW-1:0]; sar SHALL give arithmetic a >>> b[SHW-1:0]; shr1 SHALL give {0,a[WIDTH-1:1]} with carry_out=a[0]; b bits above SHW ignored.
REQ-017 mul low-half SHALL give a[WIDTH/2-1:0]*b[WIDTH/2-1:0] (full WIDTH product); mul low/high SHALL give the low/high WIDTH bits of the unsigned 2*WIDTH product.
REQ-018 udiv/urem SHALL give unsigned quotient/remainder via restoring shift-subtract, one quotient bit per cycle.
REQ-019 b=0 on udiv SHALL give c = all ones, on urem c = a; div_by_zero=1; latency unchanged.
REQ-020 FSM states SHALL be IDLE, MUL, DIV; IDLE->MUL on accepted mul op, IDLE->DIV on accepted div/rem op, all other accepted ops stay IDLE.
REQ-021 Latency (accept edge to valid=1): single-cycle ops 1 cycle, mul ops 2 cycles, div/rem WIDTH+1 cycles.
REQ-022 busy SHALL be 1 from the cycle after acceptance of a mul/div op until the cycle valid=1, inclusive of neither; single-cycle ops never raise busy.
REQ-023 start while busy=1 SHALL be ignored and not queued; start in the same cycle valid=1 with busy=0 SHALL be accepted (back-to-back).
REQ-024 c and flags SHALL update only in the cycle valid=1 and hold until the next valid.
REQ-025 is_zero SHALL be (c=0), is_negative SHALL be c[WIDTH-1]; div_by_zero SHALL be 0 for non-div ops.
REQ-026 Division cycle counter SHALL count WIDTH iterations exactly, no early termination.

Reset
REQ-027 resetn=0 SHALL immediately force state IDLE, c=0, carry_out=0, is_zero=0, is_negative=0, div_by_zero=0, busy=0, valid=0, counter=0.
REQ-028 reset during MUL/DIV SHALL abort without producing valid; first start after release is accepted normally.

Verification
REQ-029 WIDTH=32: add a=FFFFFFFF b=1 -> 1 cycle, c=0, carry_out=1, is_zero=1.
REQ-030 udiv a=100 b=7 -> valid at 33 cycles, c=14; urem same -> c=2; busy high for 31 cycles.
REQ-031 udiv a=5 b=0 -> c=FFFFFFFF, div_by_zero=1; urem -> c=5, div_by_zero=1.
REQ-032 mul high a=FFFFFFFF b=FFFFFFFF -> valid at 2 cycles, c=FFFFFFFE; mul low -> c=1; sar a=80000000 b=31 -> c=FFFFFFFF, is_negative=1.
REQ-033 start udiv, pulse start with add at cycle 5, resetn low at cycle 10 -> add ignored, no valid, all outputs 0; new add after release -> valid 1 cycle later.
REQ-034 Random regression WIDTH=8 and 64: every op vs. reference model, back-to-back starts, c/flags stable between valids.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU. Logic/arith/shift ops finish in one cycle, multiply
// in two, and unsigned divide/remainder run a WIDTH-step restoring divider.
module alu_mc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [7:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] c,
    output logic             carry_out,
    output logic             is_zero,
    output logic             is_negative,
    output logic             div_by_zero,
    output logic             busy,
    output logic             valid
);

    localparam int unsigned       CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]     CntLast  = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  One      = WIDTH'(1);
    localparam logic [WIDTH-1:0]  HalfMask = WIDTH'({(WIDTH/2){1'b1}});

    localparam logic [4:0] OpAdd = 5'd0,  OpAdc = 5'd1,  OpSub = 5'd2,  OpSbc = 5'd3;
    localparam logic [4:0] OpOr  = 5'd4,  OpAnd = 5'd5,  OpNot = 5'd6,  OpXor = 5'd7;
    localparam logic [4:0] OpCmp = 5'd8,  OpPass = 5'd9, OpShl = 5'd12, OpShr1 = 5'd13;
    localparam logic [4:0] OpSar = 5'd14, OpMulHalf = 5'd16, OpMulLo = 5'd17;
    localparam logic [4:0] OpMulHi = 5'd18, OpUdiv = 5'd20, OpUrem = 5'd21;

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   c_q, c_d;
    logic               carry_q, carry_d, zero_q, zero_d, neg_q, neg_d;
    logic               dbz_q, dbz_d, busy_q, busy_d, valid_q, valid_d;
    // a_q doubles as the dividend/quotient shift register during a divide
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, rem_q, rem_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [4:0]         sel_q, sel_d;

    logic [4:0]         opc;
    logic               accept, is_mul, is_div;
    logic [SHW-1:0]     shamt;
    logic [WIDTH:0]     sum, diff;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_carry;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mul_res;
    logic [WIDTH:0]     trial, trial_sub;
    logic               ge;
    logic [WIDTH-1:0]   rem_n, quo_n;
    logic               unused_bits;

    assign opc         = op[4:0];
    assign accept      = start && (state_q == StIdle);
    assign is_mul      = (opc == OpMulHalf) || (opc == OpMulLo) || (opc == OpMulHi);
    assign is_div      = (opc == OpUdiv) || (opc == OpUrem);
    assign shamt       = b[SHW-1:0];
    assign unused_bits = ^{op[7:5], trial_sub[WIDTH]};

    // Single-cycle result computed straight from the input operands
    always_comb begin
        sum      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (opc == OpAdc) && carry_in};
        diff     = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (opc == OpSbc) && carry_in};
        sc_res   = '0;
        sc_carry = 1'b0;
        case (opc)
            OpAdd, OpAdc: begin sc_res = sum[WIDTH-1:0];  sc_carry = sum[WIDTH];  end
            OpSub, OpSbc: begin sc_res = diff[WIDTH-1:0]; sc_carry = diff[WIDTH]; end
            OpOr:   sc_res = a | b;
            OpAnd:  sc_res = a & b;
            OpNot:  sc_res = ~a;
            OpXor:  sc_res = a ^ b;
            OpCmp:  sc_res = diff[WIDTH-1] ? '1 : ((a == b) ? '0 : One);
            OpPass: sc_res = a;
            OpShl:  sc_res = a << shamt;
            OpShr1: begin sc_res = {1'b0, a[WIDTH-1:1]}; sc_carry = a[0]; end
            OpSar:  sc_res = $signed(a) >>> shamt;
            default: ;
        endcase
    end

    // Multiplier on latched operands and one restoring-division step
    always_comb begin
        prod      = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        mul_res   = (sel_q == OpMulHi) ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
        trial     = {rem_q, a_q[WIDTH-1]};
        trial_sub = trial - {1'b0, b_q};
        ge        = trial >= {1'b0, b_q};
        rem_n     = ge ? trial_sub[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_n     = {a_q[WIDTH-2:0], ge};
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) begin
                if (is_mul)      state_d = StMul;
                else if (is_div) state_d = StDiv;
            end
            StMul:  state_d = StIdle;
            StDiv:  if (cnt_q == CntLast) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath next values; results and flags move only with valid
    always_comb begin
        c_d     = c_q;
        carry_d = carry_q;
        dbz_d   = dbz_q;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        unique case (state_q)
            StIdle: if (accept) begin
                sel_d = opc;
                a_d   = a;
                b_d   = b;
                rem_d = '0;
                cnt_d = '0;
                if (opc == OpMulHalf) begin
                    a_d = a & HalfMask;
                    b_d = b & HalfMask;
                end
                if (!is_mul && !is_div) begin
                    c_d     = sc_res;
                    carry_d = sc_carry;
                    dbz_d   = 1'b0;
                    valid_d = 1'b1;
                end
            end
            StMul: begin
                c_d     = mul_res;
                carry_d = 1'b0;
                dbz_d   = 1'b0;
                valid_d = 1'b1;
            end
            StDiv: begin
                a_d    = quo_n;
                rem_d  = rem_n;
                cnt_d  = cnt_q + CW'(1);
                // busy drops in the same edge that raises valid
                busy_d = (cnt_q != CntLast);
                if (cnt_q == CntLast) begin
                    // b=0 naturally yields all-ones quotient and remainder a
                    c_d     = (sel_q == OpUrem) ? rem_n : quo_n;
                    carry_d = 1'b0;
                    dbz_d   = (b_q == '0);
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
        zero_d = valid_d ? (c_d == '0) : zero_q;
        neg_d  = valid_d ? c_d[WIDTH-1] : neg_q;
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            c_q     <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
        end else begin
            c_q     <= c_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    assign c           = c_q;
    assign carry_out   = carry_q;
    assign is_zero     = zero_q;
    assign is_negative = neg_q;
    assign div_by_zero = dbz_q;
    assign busy        = busy_q;
    assign valid       = valid_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and randomised checks of alu_mc against an arithmetic model.
module tb_alu_mc;

    localparam int W = 32;

    logic         clk, resetn, start, carry_in;
    logic [7:0]   op;
    logic [W-1:0] a, b, c;
    logic         carry_out, is_zero, is_negative, div_by_zero, busy, valid;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int           due;
        int           bs;
        int           be;
        logic [W-1:0] c;
        logic         co;
        logic         dz;
    } exp_t;
    exp_t q[$];

    logic [W-1:0] h_c;
    logic         h_co, h_z, h_n, h_dz;

    alu_mc #(.WIDTH(W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .carry_in    (carry_in),
        .c           (c),
        .carry_out   (carry_out),
        .is_zero     (is_zero),
        .is_negative (is_negative),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .valid       (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [W+7:0] got, input logic [W+7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, got, exp);
        end
    endtask

    // Reference behaviour from the operation definitions
    function automatic void model(input logic [4:0] o, input logic [W-1:0] x,
                                  input logic [W-1:0] y, input logic ci,
                                  output logic [W-1:0] r, output logic co,
                                  output logic dz, output int lat);
        logic [2*W-1:0] xw, yw, cw, wide;
        xw = {{W{1'b0}}, x};
        yw = {{W{1'b0}}, y};
        cw = {{(2*W-1){1'b0}}, ci};
        r = '0; co = 1'b0; dz = 1'b0; lat = 1;
        case (o)
            5'd0:  begin wide = xw + yw;      r = wide[W-1:0]; co = wide[W]; end
            5'd1:  begin wide = xw + yw + cw; r = wide[W-1:0]; co = wide[W]; end
            5'd2:  begin r = x - y; co = (x < y); end
            5'd3:  begin wide = xw - yw - cw; r = wide[W-1:0]; co = (xw < yw + cw); end
            5'd4:  r = x | y;
            5'd5:  r = x & y;
            5'd6:  r = ~x;
            5'd7:  r = x ^ y;
            5'd8:  begin wide = xw - yw; r = wide[W-1] ? '1 : ((x == y) ? '0 : W'(1)); end
            5'd9:  r = x;
            5'd12: r = x << (y % W);
            5'd13: begin r = x >> 1; co = x[0]; end
            5'd14: r = $signed(x) >>> (y % W);
            5'd16: begin
                wide = {{(W+W/2){1'b0}}, x[W/2-1:0]} * {{(W+W/2){1'b0}}, y[W/2-1:0]};
                r = wide[W-1:0]; lat = 2;
            end
            5'd17: begin wide = xw * yw; r = wide[W-1:0];   lat = 2; end
            5'd18: begin wide = xw * yw; r = wide[2*W-1:W]; lat = 2; end
            5'd20: begin lat = W + 1; dz = (y == 0); r = dz ? '1 : x / y; end
            5'd21: begin lat = W + 1; dz = (y == 0); r = dz ? x : x % y; end
            default: ;
        endcase
    endfunction

    // Drive a start for one cycle and queue what the DUT must produce
    task automatic send(input logic [7:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, output int lat);
        exp_t         e;
        logic [W-1:0] r;
        logic         co, dz;
        model(o[4:0], x, y, ci, r, co, dz, lat);
        op = o; a = x; b = y; carry_in = ci; start = 1'b1;
        e.due = cyc + lat; e.bs = cyc + 2; e.be = cyc + lat - 1;
        e.c = r; e.co = co; e.dz = dz;
        q.push_back(e);
    endtask

    // Run one op to its valid cycle; optionally pulse a stray start at cycle poke_at
    task automatic issue(input logic [7:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input int poke_at);
        int lat;
        send(o, x, y, ci, lat);
        for (int i = 1; i <= lat; i++) begin
            @(posedge clk);
            #1;
            start = (i == poke_at);
            if (i == poke_at) begin
                op = 8'($urandom); a = W'($urandom); b = W'($urandom);
            end
        end
    endtask

    task automatic lat_probe(input string nm, input logic [7:0] o, input logic [W-1:0] x,
                             input logic [W-1:0] y, input logic ci,
                             input int exp_lat, input int exp_busy);
        int  lat, n, bc;
        logic got;
        n = 0; bc = 0; got = 1'b0;
        send(o, x, y, ci, lat);
        for (int i = 1; i <= 100 && !got; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n = i;
            if (busy) bc++;
            if (valid) got = 1'b1;
        end
        chk({nm, " latency"}, (W+8)'(n), (W+8)'(exp_lat));
        chk({nm, " busy cycles"}, (W+8)'(bc), (W+8)'(exp_busy));
    endtask

    task automatic expect_out(input string nm, input logic [W-1:0] ec, input logic eco,
                              input logic ez, input logic en, input logic edz);
        chk(nm, {carry_out, is_zero, is_negative, div_by_zero, c}, {eco, ez, en, edz, ec});
    endtask

    // Cycle-by-cycle compare of every output against the model's expectations
    initial forever begin
        logic exp_v, exp_b;
        @(negedge clk);
        if (!resetn) begin
            q.delete();
            h_c = '0; h_co = 1'b0; h_z = 1'b0; h_n = 1'b0; h_dz = 1'b0;
            chk("reset outputs",
                {valid, busy, carry_out, is_zero, is_negative, div_by_zero, c}, '0);
        end else begin
            exp_v = (q.size() > 0) && (q[0].due == cyc);
            exp_b = (q.size() > 0) && (cyc >= q[0].bs) && (cyc <= q[0].be);
            if (exp_v) begin
                h_c = q[0].c; h_co = q[0].co; h_dz = q[0].dz;
                h_z = (q[0].c == '0); h_n = q[0].c[W-1];
                void'(q.pop_front());
            end
            chk("cycle outputs",
                {valid, busy, carry_out, is_zero, is_negative, div_by_zero, c},
                {exp_v, exp_b, h_co, h_z, h_n, h_dz, h_c});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] r;
        logic         co, dz;
        int           lat;
        logic [4:0]   op_tab [20] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                                      5'd9, 5'd12, 5'd13, 5'd14, 5'd16, 5'd17, 5'd18,
                                      5'd20, 5'd21, 5'd10, 5'd31};
        logic [7:0]   o;
        logic [W-1:0] x, y;
        int           sel, pk;

        resetn = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; carry_in = 1'b0;
        #2 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset state", {valid, busy, carry_out, is_zero, is_negative, div_by_zero, c}, '0);
        resetn = 1'b1;

        // Pin the model with hand-computed values
        model(5'd20, 100, 7, 1'b0, r, co, dz, lat);
        chk("model udiv", {co, dz, r}, {2'b00, 32'd14});
        chk("model udiv lat", (W+8)'(lat), (W+8)'(33));
        model(5'd21, 100, 7, 1'b0, r, co, dz, lat);
        chk("model urem", {co, dz, r}, {2'b00, 32'd2});
        model(5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r, co, dz, lat);
        chk("model mulhi", {co, dz, r}, {2'b00, 32'hFFFFFFFE});
        model(5'd3, 5, 5, 1'b1, r, co, dz, lat);
        chk("model sbc", {co, dz, r}, {2'b10, 32'hFFFFFFFF});
        model(5'd8, 5, 3, 1'b0, r, co, dz, lat);
        chk("model cmp gt", {co, dz, r}, {2'b00, 32'd1});

        // Directed vectors with literal expectations
        lat_probe("add wrap", 8'd0, 32'hFFFFFFFF, 32'd1, 1'b0, 1, 0);
        expect_out("add wrap out", 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        lat_probe("udiv 100/7", 8'd20, 32'd100, 32'd7, 1'b0, 33, 31);
        expect_out("udiv 100/7 out", 32'd14, 1'b0, 1'b0, 1'b0, 1'b0);
        lat_probe("urem 100/7", 8'd21, 32'd100, 32'd7, 1'b0, 33, 31);
        expect_out("urem 100/7 out", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        lat_probe("udiv 5/0", 8'd20, 32'd5, 32'd0, 1'b0, 33, 31);
        expect_out("udiv 5/0 out", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        lat_probe("urem 5/0", 8'd21, 32'd5, 32'd0, 1'b0, 33, 31);
        expect_out("urem 5/0 out", 32'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        lat_probe("mul high", 8'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 2, 0);
        expect_out("mul high out", 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0);
        lat_probe("mul low", 8'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 2, 0);
        expect_out("mul low out", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        lat_probe("mul half", 8'd16, 32'h0001FFFF, 32'h0003FFFF, 1'b0, 2, 0);
        expect_out("mul half out", 32'hFFFE0001, 1'b0, 1'b0, 1'b1, 1'b0);
        lat_probe("sar 31", 8'd14, 32'h80000000, 32'd31, 1'b0, 1, 0);
        expect_out("sar 31 out", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        lat_probe("sar hi bits", 8'd14, 32'h80000000, 32'h3F, 1'b0, 1, 0);
        expect_out("sar hi bits out", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        lat_probe("shr1", 8'd13, 32'd3, 32'd0, 1'b0, 1, 0);
        expect_out("shr1 out", 32'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        lat_probe("cmp lt", 8'd8, 32'd3, 32'd5, 1'b0, 1, 0);
        expect_out("cmp lt out", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        lat_probe("sbc borrow", 8'd3, 32'd5, 32'd5, 1'b1, 1, 0);
        expect_out("sbc borrow out", 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        lat_probe("undefined op", 8'd10, 32'd5, 32'd5, 1'b0, 1, 0);
        expect_out("undefined op out", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        lat_probe("add upper op bits", 8'hE0, 32'd2, 32'd3, 1'b0, 1, 0);
        expect_out("add upper op bits out", 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(8'd20, 32'd1000, 32'd9, 1'b0, 5);
        expect_out("udiv with ignored start", 32'd111, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a divide with a stray start while busy
        send(8'd20, 32'd100, 32'd7, 1'b0, lat);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            start = (i == 5);
            if (i == 5) begin op = 8'd0; a = 32'd1; b = 32'd2; end
            if (i == 10) resetn = 1'b0;
        end
        #1;
        chk("async reset abort",
            {valid, busy, carry_out, is_zero, is_negative, div_by_zero, c}, '0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        lat_probe("add after reset", 8'd0, 32'd1, 32'd2, 1'b0, 1, 0);
        expect_out("add after reset out", 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomised mix with back-to-back starts and stray starts while busy
        for (int n = 0; n < 200; n++) begin
            o   = {3'($urandom), op_tab[$urandom_range(0, 19)]};
            x   = W'($urandom);
            y   = W'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0) y = '0;
            else if (sel < 4) y = W'($urandom_range(1, 20));
            pk = 0;
            if ((o[4:0] == 5'd20 || o[4:0] == 5'd21) && $urandom_range(0, 1) == 1)
                pk = $urandom_range(2, W);
            issue(o, x, y, 1'($urandom_range(0, 1)), pk);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
